fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Sequences the IF stage. Drives the PC register's write-enable and branch select, runs a request/grant/response handshake with a variable-latency instruction memory, and presents fetched instructions to the IF/ID register with a valid/ready handshake. Handles EX-stage redirects by killing wrong-path fetches. Sits between the PC register, the instruction memory port and the IF/ID pipeline register.

Parameters:
ADDR_WIDTH, 32, width of PC, branch target and instruction-memory address
CNT_WIDTH, 32, width of performance counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
pc_in  in  ADDR_WIDTH  current PC register value
pc_wr_en  out  1  PC write enable
pc_branch_taken  out  1  PC next-select; 1 = load pc_branch_addr, 0 = PC+4
pc_branch_addr  out  ADDR_WIDTH  redirect target to PC register
ex_branch_taken  in  1  redirect pulse from EX
ex_branch_addr  in  ADDR_WIDTH  redirect target from EX
imem_req  out  1  fetch request
imem_addr  out  ADDR_WIDTH  fetch address
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response valid
imem_rdata  in  32  response instruction
if_valid  out  1  IF/ID output valid
if_inst  out  32  fetched instruction
if_pc  out  ADDR_WIDTH  address of if_inst
if_ready  in  1  IF/ID accepts (0 = decode stall)
fetch_cnt  out  CNT_WIDTH  instructions delivered (if_valid & if_ready)
kill_cnt  out  CNT_WIDTH  responses dropped as wrong-path

Behaviour:
- Reset: state IDLE; if_valid=0, if_inst=0, if_pc=0, kill=0, fetch_pc=0, both counters=0; pc_wr_en=0, imem_req=0.
- States: IDLE (one cycle after reset, then REQ); REQ; WAIT; HOLD.
- REQ: imem_req=1, imem_addr=pc_in. On imem_gnt: fetch_pc<=pc_in, pc_wr_en=1 (PC+4 unless redirect), go WAIT. No grant: stay REQ, pc_wr_en=0.
- WAIT: imem_req=0. On imem_rvalid with kill=0: if_inst<=imem_rdata, if_pc<=fetch_pc, if_valid<=1, go HOLD. With kill=1: drop, kill<=0, kill_cnt+1, go REQ.
- HOLD: if_valid=1, if_inst/if_pc stable until if_ready. On if_ready: fetch_cnt+1, if_valid<=0, go REQ. No request issued in HOLD. One outstanding fetch and one held instruction max.
- Redirect (ex_branch_taken=1, any state except IDLE) has priority: same cycle pc_wr_en=1, pc_branch_taken=1, pc_branch_addr=ex_branch_addr; if_valid<=0 next cycle (held instr flushed, not counted).
  - REQ with grant same cycle: go WAIT with kill<=1.
  - REQ without grant: stay REQ; next request uses new pc_in.
  - WAIT without rvalid: kill<=1, stay WAIT.
  - WAIT with rvalid same cycle: response dropped (kill_cnt+1), go REQ.
  - HOLD: go REQ, even if if_ready=1 (instr not delivered, fetch_cnt unchanged).
- pc_branch_taken=0 and pc_branch_addr=0 whenever no redirect; pc_wr_en=0 outside grant/redirect cycles.
- imem_rvalid outside WAIT (e.g. stale response after reset mid-fetch): ignored.
- Redirect in IDLE: ignored.
- Counters wrap modulo 2^CNT_WIDTH.

Test Plan:
- Reset then pc_in=0x0, imem_gnt=1, rvalid 1 cycle later with rdata=0x00000013, if_ready=1 -> pc_wr_en pulse at grant, if_valid=1 with if_pc=0x0, if_inst=0x13; fetch_cnt=1.
- Response latency 3 cycles, if_ready=0 for 4 cycles -> if_valid/if_inst/if_pc stable for 4 cycles, no imem_req during HOLD, single fetch_cnt increment.
- Redirect to 0x100 while in WAIT, rvalid 2 cycles later -> pc_wr_en=1, pc_branch_taken=1, pc_branch_addr=0x100; response dropped, kill_cnt=1, next imem_addr=0x100.
- Redirect to 0x200 same cycle as imem_rvalid -> response dropped, if_valid stays 0, kill_cnt+1, state REQ.
- Redirect to 0x40 in HOLD with if_ready=1 -> if_valid=0 next cycle, fetch_cnt unchanged, next fetch at 0x40.
- Reset asserted in WAIT, imem_rvalid arrives 1 cycle after reset release -> ignored, if_valid=0, counters 0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// IF-stage sequencer: one outstanding imem fetch, one held instruction, and
// redirect handling that kills wrong-path responses.
module fetch_ctrl #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  output logic                  pc_wr_en,
  output logic                  pc_branch_taken,
  output logic [ADDR_WIDTH-1:0] pc_branch_addr,
  input  logic                  ex_branch_taken,
  input  logic [ADDR_WIDTH-1:0] ex_branch_addr,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [31:0]           imem_rdata,
  output logic                  if_valid,
  output logic [31:0]           if_inst,
  output logic [ADDR_WIDTH-1:0] if_pc,
  input  logic                  if_ready,
  output logic [CNT_WIDTH-1:0]  fetch_cnt,
  output logic [CNT_WIDTH-1:0]  kill_cnt
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

  state_e                state_q;
  logic                  kill_q;
  logic [ADDR_WIDTH-1:0] fetch_pc_q;
  logic                  redirect;

  assign redirect = ex_branch_taken && (state_q != StIdle) && !rst;

  // PC and imem controls must act in the same cycle as grant/redirect.
  always_comb begin
    pc_wr_en        = 1'b0;
    pc_branch_taken = 1'b0;
    pc_branch_addr  = '0;
    imem_req        = 1'b0;
    imem_addr       = '0;
    if (!rst) begin
      if (state_q == StReq) begin
        imem_req  = 1'b1;
        imem_addr = pc_in;
        pc_wr_en  = imem_gnt;
      end
      if (redirect) begin
        pc_wr_en        = 1'b1;
        pc_branch_taken = 1'b1;
        pc_branch_addr  = ex_branch_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      kill_q     <= 1'b0;
      fetch_pc_q <= '0;
      if_valid   <= 1'b0;
      if_inst    <= '0;
      if_pc      <= '0;
      fetch_cnt  <= '0;
      kill_cnt   <= '0;
    end else begin
      unique case (state_q)
        StIdle: state_q <= StReq;
        StReq: begin
          if (imem_gnt) begin
            fetch_pc_q <= pc_in;
            state_q    <= StWait;
            if (redirect) kill_q <= 1'b1;
          end
        end
        StWait: begin
          if (imem_rvalid) begin
            if (kill_q || redirect) begin
              kill_q   <= 1'b0;
              kill_cnt <= kill_cnt + 1'b1;
              state_q  <= StReq;
            end else begin
              if_inst  <= imem_rdata;
              if_pc    <= fetch_pc_q;
              if_valid <= 1'b1;
              state_q  <= StHold;
            end
          end else if (redirect) begin
            kill_q <= 1'b1;
          end
        end
        StHold: begin
          // A redirect flushes the held instruction even if decode accepts it.
          if (redirect) begin
            if_valid <= 1'b0;
            state_q  <= StReq;
          end else if (if_ready) begin
            fetch_cnt <= fetch_cnt + 1'b1;
            if_valid  <= 1'b0;
            state_q   <= StReq;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: normal fetch, decode stall, and redirect/kill cases.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_wr_en, pc_branch_taken;
  logic [31:0] pc_branch_addr;
  logic        ex_branch_taken;
  logic [31:0] ex_branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_inst, if_pc;
  logic        if_ready;
  logic [31:0] fetch_cnt, kill_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  fetch_ctrl #(.ADDR_WIDTH(32), .CNT_WIDTH(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_in           (pc_in),
    .pc_wr_en        (pc_wr_en),
    .pc_branch_taken (pc_branch_taken),
    .pc_branch_addr  (pc_branch_addr),
    .ex_branch_taken (ex_branch_taken),
    .ex_branch_addr  (ex_branch_addr),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .if_valid        (if_valid),
    .if_inst         (if_inst),
    .if_pc           (if_pc),
    .if_ready        (if_ready),
    .fetch_cnt       (fetch_cnt),
    .kill_cnt        (kill_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; pc_in = '0; ex_branch_taken = 1'b0; ex_branch_addr = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; if_ready = 1'b0;
    tick(); tick();
    #1;
    chk("rst_if_valid", if_valid, 0);
    chk("rst_if_inst", if_inst, 0);
    chk("rst_if_pc", if_pc, 0);
    chk("rst_fetch_cnt", fetch_cnt, 0);
    chk("rst_kill_cnt", kill_cnt, 0);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_pc_wr_en", pc_wr_en, 0);

    // Basic fetch at 0x0, response one cycle after grant.
    rst = 1'b0;
    #1 chk("idle_req", imem_req, 0);
    tick();
    pc_in = 32'h0; imem_gnt = 1'b1;
    #1;
    chk("t1_req", imem_req, 1);
    chk("t1_addr", imem_addr, 32'h0);
    chk("t1_wr_en", pc_wr_en, 1);
    chk("t1_br_taken", pc_branch_taken, 0);
    tick();
    imem_gnt = 1'b0; pc_in = 32'h4; imem_rvalid = 1'b1; imem_rdata = 32'h13; if_ready = 1'b1;
    #1;
    chk("t1_wait_req", imem_req, 0);
    chk("t1_wait_wr_en", pc_wr_en, 0);
    tick();
    imem_rvalid = 1'b0;
    #1;
    chk("t1_valid", if_valid, 1);
    chk("t1_if_pc", if_pc, 32'h0);
    chk("t1_if_inst", if_inst, 32'h13);
    tick();
    chk("t1_fetch_cnt", fetch_cnt, 1);
    chk("t1_valid_clr", if_valid, 0);
    chk("t1_next_addr", imem_addr, 32'h4);

    // Latency 3 response, decode stalled for 4 cycles.
    imem_gnt = 1'b1; if_ready = 1'b0;
    tick();
    imem_gnt = 1'b0; pc_in = 32'h8;
    tick();
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'hdeadbeef;
    tick();
    imem_rvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_hold_valid", if_valid, 1);
      chk("t2_hold_inst", if_inst, 32'hdeadbeef);
      chk("t2_hold_pc", if_pc, 32'h4);
      chk("t2_hold_noreq", imem_req, 0);
      chk("t2_hold_cnt", fetch_cnt, 1);
      tick();
    end
    if_ready = 1'b1;
    tick();
    chk("t2_fetch_cnt", fetch_cnt, 2);
    chk("t2_valid_clr", if_valid, 0);

    // Redirect to 0x100 in WAIT, stale response two cycles later.
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; pc_in = 32'hc; ex_branch_taken = 1'b1; ex_branch_addr = 32'h100;
    #1;
    chk("t3_wr_en", pc_wr_en, 1);
    chk("t3_br_taken", pc_branch_taken, 1);
    chk("t3_br_addr", pc_branch_addr, 32'h100);
    tick();
    ex_branch_taken = 1'b0; pc_in = 32'h100;
    #1;
    chk("t3_br_taken_off", pc_branch_taken, 0);
    chk("t3_br_addr_off", pc_branch_addr, 0);
    chk("t3_wr_en_off", pc_wr_en, 0);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'hbad;
    tick();
    imem_rvalid = 1'b0;
    #1;
    chk("t3_kill_cnt", kill_cnt, 1);
    chk("t3_valid", if_valid, 0);
    chk("t3_req", imem_req, 1);
    chk("t3_addr", imem_addr, 32'h100);

    // Redirect to 0x200 in the same cycle as the response.
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; pc_in = 32'h104; imem_rvalid = 1'b1; imem_rdata = 32'h55;
    ex_branch_taken = 1'b1; ex_branch_addr = 32'h200;
    #1 chk("t4_br_addr", pc_branch_addr, 32'h200);
    tick();
    ex_branch_taken = 1'b0; imem_rvalid = 1'b0; pc_in = 32'h200;
    #1;
    chk("t4_valid", if_valid, 0);
    chk("t4_kill_cnt", kill_cnt, 2);
    chk("t4_req", imem_req, 1);
    chk("t4_addr", imem_addr, 32'h200);

    // Fetch 0x200, then redirect to 0x40 while held with if_ready=1.
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; pc_in = 32'h204; imem_rvalid = 1'b1; imem_rdata = 32'h77;
    tick();
    imem_rvalid = 1'b0; if_ready = 1'b1; ex_branch_taken = 1'b1; ex_branch_addr = 32'h40;
    #1;
    chk("t5_valid", if_valid, 1);
    chk("t5_inst", if_inst, 32'h77);
    chk("t5_pc", if_pc, 32'h200);
    chk("t5_wr_en", pc_wr_en, 1);
    chk("t5_br_addr", pc_branch_addr, 32'h40);
    tick();
    ex_branch_taken = 1'b0; pc_in = 32'h40;
    #1;
    chk("t5_flush", if_valid, 0);
    chk("t5_fetch_cnt", fetch_cnt, 2);
    chk("t5_kill_cnt", kill_cnt, 2);
    chk("t5_addr", imem_addr, 32'h40);

    // Reset in WAIT; stale response after release, redirect in IDLE ignored.
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h99;
    ex_branch_taken = 1'b1; ex_branch_addr = 32'h300;
    #1;
    chk("t6_idle_wr_en", pc_wr_en, 0);
    chk("t6_idle_br", pc_branch_taken, 0);
    chk("t6_idle_req", imem_req, 0);
    tick();
    ex_branch_taken = 1'b0;
    #1;
    chk("t6_valid", if_valid, 0);
    chk("t6_req", imem_req, 1);
    tick();
    imem_rvalid = 1'b0;
    #1;
    chk("t6_valid2", if_valid, 0);
    chk("t6_fetch_cnt", fetch_cnt, 0);
    chk("t6_kill_cnt", kill_cnt, 0);
    chk("t6_still_req", imem_req, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
